// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the execute-stage ALU: the 5-bit operation code, the
// operation class used to route an op to the base datapath or to the
// iterative multiply/divide engine, the top-level FSM state, and the default
// operand width.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_SLL    = 5'h02,
        OP_SLT    = 5'h03,
        OP_SLTU   = 5'h04,
        OP_XOR    = 5'h05,
        OP_SRL    = 5'h06,
        OP_SRA    = 5'h07,
        OP_OR     = 5'h08,
        OP_AND    = 5'h09,
        OP_PASSB  = 5'h0A,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } aluop_e;

    typedef enum logic [1:0] {
        CLS_BASE,
        CLS_MUL,
        CLS_DIV
    } opclass_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    // 0x10-0x13 multiply, 0x14-0x17 divide/remainder; every other code
    // (including the unused 0x18-0x1F) completes with base latency.
    function automatic opclass_e op_class(input logic [4:0] op);
        opclass_e cls;
        cls = CLS_BASE;
        if (op[4:3] == 2'b10) begin
            cls = op[2] ? CLS_DIV : CLS_MUL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/alu_md_if.sv
// -----------------------------------------------------------------------------
// alu_md_if
// Issue/result handshake bundle of the execute-stage ALU.
//   in_valid/in_ready   : operation transfer from the issue stage
//   aluop, opr_a, opr_b : operation code and operands
//   out_valid/out_ready : result transfer to the consumer
//   opr_res             : result, stable while out_valid && !out_ready
//   busy                : an iterative multiply/divide is in progress
// slave  : the ALU side
// master : the issue/consumer side
// -----------------------------------------------------------------------------
interface alu_md_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      aluop;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] opr_res;
    logic            busy;

    modport slave (
        input  in_valid, aluop, opr_a, opr_b, out_ready,
        output in_ready, out_valid, opr_res, busy
    );

    modport master (
        output in_valid, aluop, opr_a, opr_b, out_ready,
        input  in_ready, out_valid, opr_res, busy
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative M-extension engine: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle for XLEN cycles, with signs applied
// to the final value.
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : load op/operands (non-special MUL*/DIV*/REM* only)
//   i_op       : operation code
//   i_a, i_b   : operands (rs1, rs2)
//   o_done     : high during the last iteration cycle
//   o_result   : final result, valid while o_done is high
// -----------------------------------------------------------------------------
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  aluop_e          i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    logic              r_active;
    logic              r_is_div;
    logic              r_sel_hi;   // high half of product, or remainder
    logic              r_neg;      // negate the final value
    logic [SHW-1:0]    r_cnt;
    logic [XLEN-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] r_acc;      // mul: {partial, multiplier}; div: {rem, quotient}

    logic              w_is_div;
    logic              w_neg_a;
    logic              w_neg_b;
    logic              w_neg_res;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;

    always_comb begin
        w_is_div  = (op_class(i_op) == CLS_DIV);
        // MUL returns the low half, which does not depend on signedness.
        w_neg_a   = (i_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && i_a[XLEN-1];
        w_neg_b   = (i_op inside {OP_MULH, OP_DIV, OP_REM}) && i_b[XLEN-1];
        w_mag_a   = w_neg_a ? -i_a : i_a;
        w_mag_b   = w_neg_b ? -i_b : i_b;
        // Remainder follows the dividend; product and quotient follow the XOR.
        w_neg_res = (i_op inside {OP_REM, OP_REMU}) ? w_neg_a : (w_neg_a ^ w_neg_b);
    end

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_sel;

    always_comb begin
        // Multiply step: add multiplicand if multiplier LSB set, shift right.
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        // Divide step: shift next dividend bit into the partial remainder.
        w_shift = r_acc[2*XLEN-1:XLEN-1];
        w_diff  = w_shift - {1'b0, r_opnd};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        if (r_is_div) begin
            w_acc_next = {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]),
                          r_acc[XLEN-2:0], w_ge};
        end else begin
            w_acc_next = {w_sum, r_acc[XLEN-1:1]};
        end
        // The product sign must be applied to the full 2*XLEN value before
        // picking a half; quotient/remainder are negated individually.
        w_prod = r_neg ? -w_acc_next : w_acc_next;
        w_sel  = r_sel_hi ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
        if (r_is_div) begin
            o_result = r_neg ? -w_sel : w_sel;
        end else begin
            o_result = r_sel_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        end
    end

    assign o_done = r_active && (r_cnt == SHW'(XLEN - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_is_div <= 1'b0;
            r_sel_hi <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_is_div <= w_is_div;
            r_sel_hi <= i_op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
            r_neg    <= w_neg_res;
            r_cnt    <= '0;
            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
            r_acc    <= w_is_div ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
        end else if (r_active) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// -----------------------------------------------------------------------------
// alu_md
// Handshaked execute-stage ALU: single-cycle base integer ops plus iterative
// M-extension multiply/divide/remainder with valid/ready back-pressure.
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : alu_md_if.slave (in_valid/in_ready, aluop, opr_a, opr_b,
//          out_valid/out_ready, opr_res, busy)
// -----------------------------------------------------------------------------
module alu_md
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic     clk,
    input  logic     rst,
    alu_md_if.slave  bus
);

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_res;

    aluop_e          w_op;
    opclass_e        w_cls;
    logic [SHW-1:0]  w_sh;
    logic            w_accept;
    logic            w_special;
    logic            w_start;
    logic            w_eng_done;
    logic [XLEN-1:0] w_base_res;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_eng_res;

    assign w_op         = aluop_e'(bus.aluop);
    assign w_cls        = op_class(bus.aluop);
    assign w_sh         = bus.opr_b[SHW-1:0];
    assign bus.in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        w_base_res = '0;
        case (w_op)
            OP_ADD:   w_base_res = bus.opr_a + bus.opr_b;
            OP_SUB:   w_base_res = bus.opr_a - bus.opr_b;
            OP_SLL:   w_base_res = bus.opr_a << w_sh;
            OP_SLT:   w_base_res = {{(XLEN-1){1'b0}}, $signed(bus.opr_a) < $signed(bus.opr_b)};
            OP_SLTU:  w_base_res = {{(XLEN-1){1'b0}}, bus.opr_a < bus.opr_b};
            OP_XOR:   w_base_res = bus.opr_a ^ bus.opr_b;
            OP_SRL:   w_base_res = bus.opr_a >> w_sh;
            OP_SRA:   w_base_res = $unsigned($signed(bus.opr_a) >>> w_sh);
            OP_OR:    w_base_res = bus.opr_a | bus.opr_b;
            OP_AND:   w_base_res = bus.opr_a & bus.opr_b;
            OP_PASSB: w_base_res = bus.opr_b;
            default:  w_base_res = '0;
        endcase
    end

    // Divide-by-zero and signed overflow have fixed results and bypass the
    // iterative engine entirely.
    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (w_cls == CLS_DIV) begin
            if (bus.opr_b == '0) begin
                w_special     = 1'b1;
                w_special_res = (w_op inside {OP_REM, OP_REMU}) ? bus.opr_a : '1;
            end else if ((w_op inside {OP_DIV, OP_REM}) &&
                         (bus.opr_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (bus.opr_b == '1)) begin
                w_special     = 1'b1;
                w_special_res = (w_op == OP_DIV) ? bus.opr_a : '0;
            end
        end
    end

    assign w_start = w_accept && ((w_cls == CLS_MUL) || ((w_cls == CLS_DIV) && !w_special));

    alu_muldiv_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_op     (w_op),
        .i_a      (bus.opr_a),
        .i_b      (bus.opr_b),
        .o_done   (w_eng_done),
        .o_result (w_eng_res)
    );

    // NOTE: the next state gets a default before the case so that every path
    // assigns it; a missing assignment in always_comb would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_cls == CLS_MUL) begin
                        w_state_next = ST_MUL;
                    end else if ((w_cls == CLS_DIV) && !w_special) begin
                        w_state_next = ST_DIV;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else if ((r_state == ST_IDLE) || bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_eng_done) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_res   <= '0;
        end else begin
            r_state <= w_state_next;
            // Result register only loads on a completion, so it holds while
            // the consumer stalls.
            if (w_accept && (w_state_next == ST_DONE)) begin
                r_res <= w_special ? w_special_res : w_base_res;
            end else if (w_eng_done) begin
                r_res <= w_eng_res;
            end
        end
    end

    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign bus.opr_res   = r_res;

endmodule
